mult_control: RTL
=================

# mult_control

Control unit for the 32x32 shift-add multiplier datapath. It sits directly upstream of the datapath and drives every select and shift control the datapath needs. It consumes the datapath's multiplier-LSB feedback and sequences load, 32 accumulate/shift iterations, and completion. It exposes a simple start/busy/done handshake to the block that issues multiply requests.

## Interface
Parameters:
- ITERATIONS, 32: number of accumulate/shift iterations; equals operand width.
- CNT_WIDTH, 6: iteration counter width; must satisfy 2^CNT_WIDTH > ITERATIONS.

Ports:
- Clock  input  1  single clock domain; all state updates on rising edge.
- Reset  input  1  synchronous, active-high; sampled on rising edge of Clock.
- iStart  input  1  request to multiply the operands currently on the datapath Data_A/Data_B inputs; sampled only in IDLE.
- iB_LSB  input  1  bit 0 of the datapath multiplier register.
- a_sel  output  1  datapath multiplicand mux select; 1 = load external operand, 0 = shifted feedback.
- b_sel  output  1  datapath multiplier mux select; 1 = load external operand, 0 = shifted feedback.
- prod_sel  output  1  datapath product mux select; 1 = clear product to 0, 0 = take accumulate path.
- add_sel  output  1  datapath accumulate select; 0 = product + multiplicand, 1 = hold product.
- Shift_Enable  output  1  shift strobe to datapath shifters.
- oBusy  output  1  high from LOAD through last ITER cycle.
- oDone  output  1  one-cycle pulse; product valid on datapath Prod.

## Operation
- FSM states: IDLE, LOAD, ITER, DONE. Iteration counter cnt, CNT_WIDTH bits.
- IDLE: a_sel=0, b_sel=0, prod_sel=0, add_sel=1, Shift_Enable=0, oBusy=0, oDone=0. iStart=1 -> LOAD; else stay.
- LOAD: a_sel=1, b_sel=1, prod_sel=1, add_sel=1, Shift_Enable=0, oBusy=1. Unconditional -> ITER; cnt <= 0.
- ITER: a_sel=0, b_sel=0, prod_sel=0, Shift_Enable=1, oBusy=1, add_sel = ~iB_LSB (combinational from iB_LSB; all other outputs decoded from state only). Per edge: product accumulates if LSB set, multiplicand shifts left, multiplier shifts right, cnt <= cnt+1. When cnt == ITERATIONS-1 -> DONE.
- DONE: oDone=1, oBusy=0, add_sel=1, prod_sel=0, Shift_Enable=0, a_sel=b_sel=0. Unconditional -> IDLE.
- Product is held (add_sel=1, prod_sel=0) in IDLE and DONE, so the result stays on Prod until the next LOAD.
- iStart outside IDLE is ignored; not queued.
- iStart held high continuously: new multiply starts every 35 cycles (DONE -> IDLE -> LOAD).
- Reset in any state: next edge state=IDLE, cnt=0, no oDone pulse; partial product is discarded (datapath reset clears it).
- cnt never wraps: exits ITER at ITERATIONS-1; cnt value outside ITER is don't-care but reset to 0.

## Timing
- Reset values (state IDLE): a_sel=0, b_sel=0, prod_sel=0, add_sel=1, Shift_Enable=0, oBusy=0, oDone=0, cnt=0.
- Edge E0 samples iStart=1 in IDLE; cycle after E0 is LOAD.
- Edge E1: datapath loads operands, clears product; cycles after E1..E32 are ITER (32 cycles).
- Edges E2..E33: the 32 accumulate/shift steps; final product registered at E33.
- Cycle after E33: DONE, oDone=1, Prod valid. Latency iStart-sample to oDone = 34 cycles.
- Edge E34: return to IDLE; earliest next iStart sample at E35 (E34 is a DONE edge, not sampled).
- add_sel has a same-cycle combinational path from iB_LSB; all others are registered-state decode.

## Test plan
- Reset, then Data_A=3, Data_B=5, iStart pulse 1 cycle -> oBusy high 33 cycles, oDone pulse exactly 34 cycles after iStart sample, Prod=64'd15, held until next start.
- Data_A=Data_B=32'hFFFFFFFF -> Prod=64'hFFFFFFFE00000001; add_sel=0 in all 32 ITER cycles.
- Data_A=32'h12345678, Data_B=0 -> Prod=0; add_sel=1 in every ITER cycle; oDone at same 34-cycle latency.
- iStart pulsed again at ITER cycle 10 -> ignored; single oDone; Prod equals first operand product.
- Reset asserted in ITER cycle 20 -> next cycle state IDLE, all outputs at reset values, no oDone; subsequent 7x9 returns Prod=63.
- iStart held high, operands 2x3 then 4x5 -> oDone pulses 35 cycles apart, Prod=6 then 20.

Source files
------------

// File: rtl/mult_control.sv
// Purpose : sequencing FSM for the 32x32 shift-add multiplier datapath (load, N accumulate/shift steps, done).
// Latency : oDone pulses ITERATIONS+2 cycles after iStart is sampled in IDLE (34 for the default 32 iterations).
// Backpressure: none; iStart is only looked at in IDLE, requests arriving while busy are dropped, not queued.
//
// Ports:
//   Clock, Reset      - single clock; synchronous active-high reset
//   iStart            - multiply request, sampled only in IDLE
//   iB_LSB            - bit 0 of the datapath multiplier register
//   a_sel, b_sel      - 1 = load external operand, 0 = shifted feedback
//   prod_sel          - 1 = clear product, 0 = accumulate path
//   add_sel           - 0 = product + multiplicand, 1 = hold product
//   Shift_Enable      - shift strobe for the datapath shifters
//   oBusy             - high from LOAD through the last ITER cycle
//   oDone             - one-cycle pulse, product valid on the datapath
module mult_control #(
  parameter int ITERATIONS = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iStart,
  input  logic iB_LSB,
  output logic a_sel,
  output logic b_sel,
  output logic prod_sel,
  output logic add_sel,
  output logic Shift_Enable,
  output logic oBusy,
  output logic oDone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  // Count value seen during the final ITER cycle; the FSM leaves ITER on
  // that edge so cnt never needs to wrap.
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ITERATIONS - 1);

  state_t               state;
  state_t               next_state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 last_iter;

  assign last_iter = (cnt == LAST_CNT);

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Iteration counter: cleared on the LOAD edge so the first ITER cycle
  // sees 0; its value outside ITER is unused.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
    end else begin
      case (state)
        LOAD:    cnt <= '0;
        ITER:    cnt <= cnt + 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = iStart ? LOAD : IDLE;
      LOAD:    next_state = ITER;
      ITER:    next_state = last_iter ? DONE : ITER;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode. Everything is a pure state decode except add_sel in ITER,
  // which follows the multiplier LSB in the same cycle so the accumulate
  // decision lands on the very edge that shifts that bit out.
  always_comb begin
    a_sel        = 1'b0;
    b_sel        = 1'b0;
    prod_sel     = 1'b0;
    add_sel      = 1'b1;
    Shift_Enable = 1'b0;
    oBusy        = 1'b0;
    oDone        = 1'b0;
    case (state)
      IDLE: begin
        // product held so the previous result stays visible
      end
      LOAD: begin
        a_sel    = 1'b1;
        b_sel    = 1'b1;
        prod_sel = 1'b1;
        oBusy    = 1'b1;
      end
      ITER: begin
        add_sel      = ~iB_LSB;
        Shift_Enable = 1'b1;
        oBusy        = 1'b1;
      end
      DONE: begin
        oDone = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
